eth_udp_gen: RTL and testbench

- Builds the IPv4 and UDP headers for one user payload and streams the result byte-by-byte into eth_tx through its Eth_Byte / Eth_Byte_Valid / Eth_Pkt_Rdy inputs.
- Sits directly upstream of eth_tx, which prepends preamble, SFD, MAC addresses and EtherType 0x0800.
- Computes the IPv4 header checksum and pads short frames to the Ethernet minimum payload of 46 bytes.

---
 rtl/eth_udp_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_eth_udp_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_udp_gen.sv
// rtl/eth_udp_gen.sv - IPv4/UDP header generator feeding the eth_tx byte FIFO
//
// Builds a 20-byte IPv4 header (with header checksum) and an 8-byte UDP
// header for one user payload, streams header, payload and zero padding
// byte-by-byte into eth_tx, then pulses Eth_Pkt_Rdy.
//
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   Start, Usr_Len    packet request and UDP payload length (sampled in IDLE)
//   Usr_Byte/_Valid   user payload byte stream in
//   Usr_Byte_Rdy      payload byte accepted this cycle
//   Fifo_Afull        eth_tx FIFO almost full, stalls byte emission
//   Eth_Byte/_Valid   registered byte and write strobe to eth_tx FIFO
//   Eth_Pkt_Rdy       one-cycle pulse once the whole packet is in the FIFO
//   Busy              high outside IDLE
//   Len_Err           one-cycle pulse when Usr_Len > pMAX_LEN on Start

`timescale 1ns/1ps

module eth_udp_gen #(
    parameter logic [31:0] pSRC_IP   = 32'hC0A8010A,
    parameter logic [31:0] pDST_IP   = 32'hC0A80101,
    parameter logic [15:0] pSRC_PORT = 16'd5000,
    parameter logic [15:0] pDST_PORT = 16'd5001,
    parameter logic [7:0]  pTTL      = 8'd64,
    parameter logic [15:0] pMAX_LEN  = 16'd1472
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [15:0] Usr_Len,
    input  logic [7:0]  Usr_Byte,
    input  logic        Usr_Byte_Valid,
    output logic        Usr_Byte_Rdy,
    input  logic        Fifo_Afull,
    output logic [7:0]  Eth_Byte,
    output logic        Eth_Byte_Valid,
    output logic        Eth_Pkt_Rdy,
    output logic        Busy,
    output logic        Len_Err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CSUM, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_PAD, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;         // word / byte index within the current state
    logic [15:0] rem_q, rem_d;         // payload bytes still to accept
    logic [15:0] len_q, len_d;
    logic [15:0] ident_q, ident_d;     // free-running IPv4 identification
    logic [15:0] pkt_ident_q, pkt_ident_d;
    logic [15:0] sum_q, sum_d;         // ones-complement running sum
    logic [7:0]  eth_byte_q, eth_byte_d;
    logic        eth_valid_q, eth_valid_d;
    logic        pkt_rdy_q, pkt_rdy_d;
    logic        len_err_q, len_err_d;

    logic [15:0]  csum_word;
    logic [16:0]  add_s;
    logic [159:0] ip_hdr, ip_sh;
    logic [63:0]  udp_hdr, udp_sh;
    logic [15:0]  pad_last;
    logic         short_pkt;

    assign ip_hdr  = {16'h4500, len_q + 16'd28, pkt_ident_q, 16'h4000,
                      pTTL, 8'h11, ~sum_q, pSRC_IP, pDST_IP};
    assign udp_hdr = {pSRC_PORT, pDST_PORT, len_q + 16'd8, 16'h0000};
    // Shift the addressed byte to the top instead of a variable part-select.
    assign ip_sh   = ip_hdr << {cnt_q[4:0], 3'b000};
    assign udp_sh  = udp_hdr << {cnt_q[2:0], 3'b000};

    assign short_pkt = (len_q < 16'd18);       // 28+L < 46 needs padding
    assign pad_last  = 16'd17 - len_q;         // index of last pad byte (18-L bytes)

    always_comb begin
        case (cnt_q[3:0])
            4'd0:    csum_word = 16'h4500;
            4'd1:    csum_word = len_q + 16'd28;
            4'd2:    csum_word = pkt_ident_q;
            4'd3:    csum_word = 16'h4000;
            4'd4:    csum_word = {pTTL, 8'h11};
            4'd6:    csum_word = pSRC_IP[31:16];
            4'd7:    csum_word = pSRC_IP[15:0];
            4'd8:    csum_word = pDST_IP[31:16];
            4'd9:    csum_word = pDST_IP[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    assign add_s        = {1'b0, sum_q} + {1'b0, csum_word};
    assign Usr_Byte_Rdy = (state_q == S_PAYLOAD) && !Fifo_Afull && (rem_q != 16'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        len_d       = len_q;
        ident_d     = ident_q;
        pkt_ident_d = pkt_ident_q;
        sum_d       = sum_q;
        eth_byte_d  = 8'h00;
        eth_valid_d = 1'b0;
        pkt_rdy_d   = 1'b0;
        len_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Usr_Len > pMAX_LEN) begin
                        len_err_d = 1'b1;
                    end else begin
                        len_d       = Usr_Len;
                        pkt_ident_d = ident_q;
                        sum_d       = 16'h0000;
                        cnt_d       = 16'd0;
                        state_d     = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                // End-around carry folded back after every add.
                sum_d = add_s[15:0] + {15'd0, add_s[16]};
                if (cnt_q == 16'd9) begin
                    cnt_d   = 16'd0;
                    state_d = S_IP_HDR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_IP_HDR: begin
                if (!Fifo_Afull) begin
                    eth_byte_d  = ip_sh[159:152];
                    eth_valid_d = 1'b1;
                    if (cnt_q == 16'd19) begin
                        cnt_d   = 16'd0;
                        state_d = S_UDP_HDR;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_UDP_HDR: begin
                if (!Fifo_Afull) begin
                    eth_byte_d  = udp_sh[63:56];
                    eth_valid_d = 1'b1;
                    if (cnt_q == 16'd7) begin
                        cnt_d = 16'd0;
                        rem_d = len_q;
                        if (len_q != 16'd0) state_d = S_PAYLOAD;
                        else                state_d = S_PAD;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (Usr_Byte_Valid && Usr_Byte_Rdy) begin
                    eth_byte_d  = Usr_Byte;
                    eth_valid_d = 1'b1;
                    rem_d       = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = short_pkt ? S_PAD : S_DONE;
                    end
                end
            end
            S_PAD: begin
                if (!Fifo_Afull) begin
                    eth_byte_d  = 8'h00;
                    eth_valid_d = 1'b1;
                    if (cnt_q == pad_last) begin
                        cnt_d   = 16'd0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_DONE: begin
                // First DONE cycle: last byte is being written. Second cycle:
                // Eth_Pkt_Rdy is high while still busy, so a coincident Start
                // is ignored.
                if (cnt_q == 16'd0) begin
                    pkt_rdy_d = 1'b1;
                    cnt_d     = 16'd1;
                end else begin
                    cnt_d   = 16'd0;
                    ident_d = ident_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            rem_q       <= 16'd0;
            len_q       <= 16'd0;
            ident_q     <= 16'h0000;
            pkt_ident_q <= 16'h0000;
            sum_q       <= 16'h0000;
            eth_byte_q  <= 8'h00;
            eth_valid_q <= 1'b0;
            pkt_rdy_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            len_q       <= len_d;
            ident_q     <= ident_d;
            pkt_ident_q <= pkt_ident_d;
            sum_q       <= sum_d;
            eth_byte_q  <= eth_byte_d;
            eth_valid_q <= eth_valid_d;
            pkt_rdy_q   <= pkt_rdy_d;
            len_err_q   <= len_err_d;
        end
    end

    assign Eth_Byte       = eth_byte_q;
    assign Eth_Byte_Valid = eth_valid_q;
    assign Eth_Pkt_Rdy    = pkt_rdy_q;
    assign Len_Err        = len_err_q;
    assign Busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_eth_udp_gen.sv
// tb/tb_eth_udp_gen.sv - self-checking bench for eth_udp_gen

`timescale 1ns/1ps

module tb_eth_udp_gen;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Usr_Len = 16'd0;
    logic [7:0]  Usr_Byte = 8'h00;
    logic        Usr_Byte_Valid = 1'b0;
    logic        Usr_Byte_Rdy;
    logic        Fifo_Afull = 1'b0;
    logic [7:0]  Eth_Byte;
    logic        Eth_Byte_Valid;
    logic        Eth_Pkt_Rdy;
    logic        Busy;
    logic        Len_Err;

    eth_udp_gen dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Usr_Len(Usr_Len),
        .Usr_Byte(Usr_Byte), .Usr_Byte_Valid(Usr_Byte_Valid),
        .Usr_Byte_Rdy(Usr_Byte_Rdy), .Fifo_Afull(Fifo_Afull),
        .Eth_Byte(Eth_Byte), .Eth_Byte_Valid(Eth_Byte_Valid),
        .Eth_Pkt_Rdy(Eth_Pkt_Rdy), .Busy(Busy), .Len_Err(Len_Err)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          len;
        logic [15:0] ident;
        logic [15:0] csum;      // hand-computed IPv4 header checksum
        bit          rst;       // apply reset before the packet
        bit          gaps;      // Usr_Byte_Valid drops every third cycle
        int          afull_at;  // cycle after Start edge where Afull rises
        int          afull_n;   // cycles Afull is held
        bit          mid_start; // pulse Start in the middle of the packet
        bit          start_rdy; // pulse Start in the Eth_Pkt_Rdy cycle
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [15:0] tot, ulen;
        int k, first, last, rdy_k, pl, viol;
        bit done, afull_prev, rdy_seen, afull;
        string tag;

        tag = $sformatf("v%0d", idx);
        tot  = 16'(v.len + 28);
        ulen = 16'(v.len + 8);
        exp_q = '{8'h45, 8'h00, tot[15:8], tot[7:0], v.ident[15:8], v.ident[7:0],
                  8'h40, 8'h00, 8'h40, 8'h11, v.csum[15:8], v.csum[7:0],
                  8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h01,
                  8'h13, 8'h88, 8'h13, 8'h89, ulen[15:8], ulen[7:0], 8'h00, 8'h00};
        for (int i = 0; i < v.len; i++) exp_q.push_back(8'(i));
        for (int i = v.len; i < 18; i++) exp_q.push_back(8'h00);

        if (v.rst) do_reset();
        @(negedge Clk);
        Start = 1'b1;
        Usr_Len = 16'(v.len);
        @(posedge Clk);
        k = 0; first = -1; last = -1; rdy_k = -1; pl = 0; viol = 0;
        done = 0; afull_prev = 0; rdy_seen = 0;
        while (!done && k < 4000) begin
            @(negedge Clk);
            if (Eth_Byte_Valid) begin
                got_q.push_back(Eth_Byte);
                if (first < 0) first = k;
                last = k;
                if (afull_prev) viol++;
            end
            if (Usr_Byte_Rdy) rdy_seen = 1;
            if (Eth_Pkt_Rdy) begin
                rdy_k = k;
                done = 1;
            end
            Start = (v.mid_start && k == 20);
            Usr_Len = Start ? 16'd5 : 16'(v.len);
            if (done && v.start_rdy) begin
                Start = 1'b1;
                Usr_Len = 16'd7;
            end
            afull = (v.afull_n > 0) && (k + 1 >= v.afull_at) && (k + 1 < v.afull_at + v.afull_n);
            Fifo_Afull = afull;
            afull_prev = afull;
            Usr_Byte_Valid = v.gaps ? ((k % 3) != 1) : 1'b1;
            Usr_Byte = 8'(pl);
            #1;
            if (Usr_Byte_Valid && Usr_Byte_Rdy) pl++;
            k++;
        end
        check({tag, "_pkt_rdy_seen"}, int'(done), 1);
        check({tag, "_first_valid_cycle"}, first, 11);
        check({tag, "_rdy_after_last"}, rdy_k, last + 1);
        check({tag, "_byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
        check({tag, "_afull_violations"}, viol, 0);
        if (v.len == 0) check({tag, "_usr_rdy_never"}, int'(rdy_seen), 0);
        else            check({tag, "_payload_consumed"}, pl, v.len);

        @(negedge Clk);
        Start = 1'b0;
        Fifo_Afull = 1'b0;
        Usr_Byte_Valid = 1'b0;
        check({tag, "_busy_after_done"}, int'(Busy), 0);
        if (v.start_rdy) begin
            repeat (2) begin
                @(negedge Clk);
                check({tag, "_start_at_rdy_ignored"}, int'(Busy || Eth_Byte_Valid), 0);
            end
        end
    endtask

    initial begin
        int seen, bad;
        vec_t fin;

        vecs[0] = '{18,   16'h0000, 16'hB763, 1, 0, 0,  0, 0, 0};
        vecs[1] = '{0,    16'h0000, 16'hB775, 1, 0, 0,  0, 0, 0};
        vecs[2] = '{18,   16'h0000, 16'hB763, 1, 0, 0,  0, 1, 1};
        vecs[3] = '{18,   16'h0001, 16'hB762, 0, 0, 0,  0, 0, 0};
        vecs[4] = '{100,  16'h0002, 16'hB70F, 0, 1, 40, 5, 0, 0};
        vecs[5] = '{20,   16'h0003, 16'hB75E, 0, 0, 15, 3, 0, 0};
        vecs[6] = '{3,    16'h0004, 16'hB76E, 0, 0, 42, 4, 0, 0};
        vecs[7] = '{1472, 16'h0005, 16'hB1B0, 0, 0, 0,  0, 0, 0};

        // Reset state
        repeat (2) @(negedge Clk);
        check("rst_valid",   int'(Eth_Byte_Valid), 0);
        check("rst_byte",    int'(Eth_Byte), 0);
        check("rst_pkt_rdy", int'(Eth_Pkt_Rdy), 0);
        check("rst_busy",    int'(Busy), 0);
        check("rst_len_err", int'(Len_Err), 0);
        check("rst_usr_rdy", int'(Usr_Byte_Rdy), 0);
        Rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Oversize length: Len_Err pulse only
        @(negedge Clk);
        Start = 1'b1;
        Usr_Len = 16'd1473;
        @(negedge Clk);
        Start = 1'b0;
        check("lenerr_pulse", int'(Len_Err), 1);
        check("lenerr_busy",  int'(Busy), 0);
        bad = 0;
        repeat (15) begin
            @(negedge Clk);
            if (Len_Err || Busy || Eth_Byte_Valid) bad++;
        end
        check("lenerr_quiet", bad, 0);

        // Reset in the middle of a packet
        @(negedge Clk);
        Start = 1'b1;
        Usr_Len = 16'd18;
        @(posedge Clk);
        seen = 0;
        for (int c = 0; c < 100 && seen < 10; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (Eth_Byte_Valid) seen++;
        end
        check("abort_reached_byte10", seen, 10);
        #2 Rst_n = 1'b0;
        #1;
        check("abort_valid", int'(Eth_Byte_Valid), 0);
        check("abort_busy",  int'(Busy), 0);
        check("abort_byte",  int'(Eth_Byte), 0);
        bad = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Eth_Pkt_Rdy || Eth_Byte_Valid) bad++;
        end
        Rst_n = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (Eth_Pkt_Rdy || Eth_Byte_Valid || Busy) bad++;
        end
        check("abort_no_pkt_rdy", bad, 0);

        fin = '{18, 16'h0000, 16'hB763, 0, 0, 0, 0, 0, 0};
        run_vec(fin, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
